// File: rtl/key_scan.sv
// key_scan: 4x4 keypad row scanner with per-tick debounce, one-pulse key report
// and a four-deep key history.
module key_scan #(
  parameter int TICK_DIV  = 50000,
  parameter int DEB_TICKS = 20
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        clr,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] key_data
);
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int CW = $clog2(DEB_TICKS + 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state, state_nxt;
  logic [3:0] col_m, col_s, col_n, col_lat, row_int;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [1:0] row_idx, col_idx, r_lat, c_lat;
  logic tick, one_low, rot, latch, inc, zero, push;
  assign col_n   = ~col_s;
  assign one_low = (col_n != 4'd0) && ((col_n & (col_n - 4'd1)) == 4'd0);
  assign tick    = En && (div == DW'(TICK_DIV - 1));
  assign row_idx = !row_int[0] ? 2'd0 : !row_int[1] ? 2'd1 : !row_int[2] ? 2'd2 : 2'd3;
  assign col_idx = col_n[0] ? 2'd0 : col_n[1] ? 2'd1 : col_n[2] ? 2'd2 : 2'd3;
  assign row     = En ? row_int : 4'hF;
  assign push    = En && state_nxt == PRESSED;
  always_comb begin
    state_nxt = state;
    rot = 1'b0;
    latch = 1'b0;
    inc = 1'b0;
    zero = 1'b0;
    case (state)
      SCAN: if (tick) begin
        latch = one_low;
        zero = one_low;
        rot = !one_low;
        state_nxt = one_low ? DEBOUNCE : SCAN;
      end
      DEBOUNCE: if (tick) begin
        inc = col_s == col_lat;
        rot = col_s != col_lat;
        state_nxt = col_s != col_lat ? SCAN : cnt == CW'(DEB_TICKS - 1) ? PRESSED : DEBOUNCE;
      end
      PRESSED: begin
        zero = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: if (tick) begin
        // a release only counts while every column reads idle
        zero = col_s != 4'hF || cnt == CW'(DEB_TICKS - 1);
        inc = !zero;
        rot = col_s == 4'hF && cnt == CW'(DEB_TICKS - 1);
        state_nxt = rot ? SCAN : RELEASE;
      end
      default: state_nxt = SCAN;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      state <= SCAN;
      row_int <= 4'b1110;
      div <= '0;
      cnt <= '0;
      col_lat <= 4'hF;
      r_lat <= 2'd0;
      c_lat <= 2'd0;
      key_code <= 4'd0;
      key_valid <= 1'b0;
      key_data <= 16'd0;
    end else begin
      col_m <= col;
      col_s <= col_m;
      key_valid <= push;
      if (push) key_code <= {r_lat, c_lat};
      key_data <= clr ? 16'd0 : push ? {key_data[11:0], r_lat, c_lat} : key_data;
      if (!En) begin
        state <= SCAN;
        row_int <= 4'b1110;
        div <= '0;
        cnt <= '0;
      end else begin
        state <= state_nxt;
        div <= tick ? '0 : div + 1'b1;
        cnt <= zero ? '0 : inc ? cnt + 1'b1 : cnt;
        if (rot) row_int <= {row_int[2:0], row_int[3]};
        if (latch) begin
          r_lat <= row_idx;
          c_lat <= col_idx;
          col_lat <= col_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: keypad-model driven bench; expected key reports are queued at
// press time and matched against each key_valid pulse.
module tb_key_scan;
  logic Clk = 0, Rst_n = 0, En = 0, clr = 0;
  logic [3:0] col, row, key_code;
  logic key_valid;
  logic [15:0] key_data;
  logic kp_on = 0, f_on = 0, prev_valid = 0;
  logic [1:0] kp_r = 0, kp_c = 0;
  logic [3:0] f_val = 4'hF;
  logic [15:0] exp_data = 0;
  logic [19:0] q[$];
  int checks = 0, errors = 0, valid_cnt = 0;
  always #5 Clk = ~Clk;
  assign col = f_on ? f_val : (kp_on && !row[kp_r]) ? ~(4'b0001 << kp_c) : 4'hF;
  key_scan #(.TICK_DIV(10), .DEB_TICKS(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .clr(clr), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_data(key_data)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge Clk) begin
    if (key_valid) begin
      logic [19:0] e;
      valid_cnt++;
      chk("valid_single", prev_valid, 0);
      chk("valid_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("key_code", key_code, e[19:16]);
        chk("key_data", key_data, e[15:0]);
      end
    end
    prev_valid = key_valid;
  end
  task automatic expect_key(logic [3:0] code);
    exp_data = {exp_data[11:0], code};
    q.push_back({code, exp_data});
  endtask
  task automatic press(logic [1:0] r, logic [1:0] c, int hold);
    int v0 = valid_cnt;
    expect_key({r, c});
    kp_r = r;
    kp_c = c;
    kp_on = 1;
    repeat (hold) @(negedge Clk);
    kp_on = 0;
    repeat (60) @(negedge Clk);
    chk("press_pulses", valid_cnt - v0, 1);
  endtask
  task automatic wait_row_change(bit timed);
    logic [3:0] prev = row;
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (row == prev && n < 40);
    chk("row_rot", row, {prev[2:0], prev[3]});
    if (timed) chk("row_period", n, 10);
  endtask
  task automatic wait_valid(int max, output int n);
    n = 0;
    while (!key_valid && n < max) begin
      @(negedge Clk);
      n++;
    end
    chk("valid_seen", key_valid, 1);
  endtask
  task automatic align();
    @(negedge Clk);
    En = 0;
    @(negedge Clk);
    En = 1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, v0;
    repeat (3) @(negedge Clk);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_data", key_data, 0);
    chk("rst_row_dis", row, 4'hF);
    Rst_n = 1;
    @(negedge Clk);
    En = 1;
    #1 chk("row_start", row, 4'b1110);
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) wait_row_change(1);
    chk("idle_no_valid", valid_cnt - v0, 0);
    // held key gives a single report
    press(2, 1, 200);
    chk("k9_code", key_code, 4'h9);
    chk("k9_data", key_data, 16'h0009);
    press(0, 1, 120);
    press(0, 2, 120);
    press(0, 3, 120);
    press(1, 0, 120);
    press(1, 1, 120);
    chk("seq_data", key_data, 16'h2345);
    @(negedge Clk);
    clr = 1;
    @(negedge Clk);
    clr = 0;
    exp_data = 0;
    chk("clr_data", key_data, 16'h0000);
    chk("clr_code", key_code, 4'h5);
    // bounce: two matches, one idle tick, then a clean three-tick press on row 1
    expect_key(4'h5);
    f_on = 1;
    f_val = 4'b1101;
    align();
    repeat (32) @(negedge Clk);
    f_val = 4'hF;
    repeat (10) @(negedge Clk);
    f_val = 4'b1101;
    wait_valid(60, n);
    chk("bounce_delay", n, 38);
    f_val = 4'hF;
    repeat (60) @(negedge Clk);
    chk("bounce_data", key_data, 16'h0005);
    // two columns low is ignored
    f_val = 4'b1001;
    v0 = valid_cnt;
    wait_row_change(0);
    for (int i = 0; i < 3; i++) wait_row_change(1);
    chk("multi_no_valid", valid_cnt - v0, 0);
    f_on = 0;
    f_val = 4'hF;
    repeat (30) @(negedge Clk);
    // En drop while waiting for release
    expect_key(4'hE);
    kp_r = 3;
    kp_c = 2;
    kp_on = 1;
    wait_valid(200, n);
    repeat (25) @(negedge Clk);
    En = 0;
    #1 chk("en_off_row", row, 4'hF);
    kp_on = 0;
    repeat (50) @(negedge Clk);
    chk("en_off_data", key_data, 16'h005E);
    chk("en_off_code", key_code, 4'hE);
    En = 1;
    #1 chk("en_on_row", row, 4'b1110);
    wait_row_change(1);
    // reset in the middle of a debounce
    f_on = 1;
    f_val = 4'b0111;
    align();
    repeat (25) @(negedge Clk);
    Rst_n = 0;
    #1;
    chk("rst_mid_valid", key_valid, 0);
    chk("rst_mid_data", key_data, 0);
    chk("rst_mid_code", key_code, 0);
    chk("rst_mid_row", row, 4'b1110);
    exp_data = 0;
    f_val = 4'hF;
    repeat (3) @(negedge Clk);
    Rst_n = 1;
    v0 = valid_cnt;
    repeat (80) @(negedge Clk);
    chk("rst_mid_no_valid", valid_cnt - v0, 0);
    f_on = 0;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
